// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream program loader for the instruction memory write port
// Frames: count byte N, 4N data bytes (big-endian words), XOR checksum byte.
module imem_loader #(
  parameter int DEPTH  = 32,
  parameter int ADDR_W = 5
) (
  input  logic              i_clock,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic              i_in_valid,
  input  logic [7:0]        i_in_data,
  output logic              o_in_ready,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [31:0]       o_mem_wdata,
  output logic              o_cpu_hold,
  output logic              o_load_done,
  output logic              o_load_error,
  output logic [ADDR_W:0]   o_words_loaded
);

  typedef enum logic [2:0] {
    S_IDLE, S_COUNT, S_DATA, S_CHECK, S_DONE, S_ERR
  } state_t;

  localparam logic [ADDR_W:0] ONE_W = 1;

  state_t            r_state, w_next;
  logic              r_in_ready;
  logic              r_mem_we;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [31:0]       r_mem_wdata;
  logic              r_cpu_hold;
  logic              r_load_done;
  logic              r_load_error;
  logic [ADDR_W:0]   r_word_idx;
  logic [ADDR_W:0]   r_count;
  logic [1:0]        r_byte_idx;
  logic [23:0]       r_word_sh;
  logic [7:0]        r_csum;

  logic w_xfer, w_start_ok, w_last_byte, w_last_word, w_count_bad;

  assign w_xfer      = i_in_valid & r_in_ready;
  assign w_start_ok  = i_start & ((r_state == S_IDLE) || (r_state == S_DONE) || (r_state == S_ERR));
  assign w_last_byte = (r_byte_idx == 2'd3);
  assign w_last_word = (r_word_idx == (r_count - ONE_W));
  assign w_count_bad = (i_in_data == 8'd0) || (i_in_data > 8'(DEPTH));

  always_ff @(posedge i_clock or negedge i_rst) begin
    if (!i_rst) r_state <= S_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (w_start_ok) w_next = S_COUNT;
      S_COUNT: if (w_xfer) w_next = w_count_bad ? S_ERR : S_DATA;
      S_DATA:  if (w_xfer && w_last_byte && w_last_word) w_next = S_CHECK;
      S_CHECK: if (w_xfer) w_next = (i_in_data == r_csum) ? S_DONE : S_ERR;
      S_DONE:  if (w_start_ok) w_next = S_COUNT;
      S_ERR:   if (w_start_ok) w_next = S_COUNT;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge i_clock or negedge i_rst) begin
    if (!i_rst) begin
      r_in_ready   <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_cpu_hold   <= 1'b1;
      r_load_done  <= 1'b0;
      r_load_error <= 1'b0;
      r_word_idx   <= '0;
      r_count      <= '0;
      r_byte_idx   <= '0;
      r_word_sh    <= '0;
      r_csum       <= '0;
    end else begin
      r_in_ready  <= (w_next == S_COUNT) || (w_next == S_DATA) || (w_next == S_CHECK);
      r_mem_we    <= 1'b0;
      r_load_done <= 1'b0;
      if (w_start_ok) begin
        r_cpu_hold   <= 1'b1;
        r_load_error <= 1'b0;
        r_word_idx   <= '0;
        r_csum       <= '0;
        r_byte_idx   <= '0;
        r_mem_addr   <= '0;
      end
      if (r_state == S_COUNT && w_xfer && !w_count_bad)
        r_count <= i_in_data[ADDR_W:0];
      if (r_state == S_DATA && w_xfer) begin
        r_csum     <= r_csum ^ i_in_data;
        r_byte_idx <= r_byte_idx + 2'd1;
        r_word_sh  <= {r_word_sh[15:0], i_in_data};
        // Fourth byte completes the word: write it out on this same edge.
        if (w_last_byte) begin
          r_mem_we    <= 1'b1;
          r_mem_wdata <= {r_word_sh, i_in_data};
          r_mem_addr  <= r_word_idx[ADDR_W-1:0];
          r_word_idx  <= r_word_idx + ONE_W;
        end
      end
      if (r_state == S_CHECK && w_next == S_DONE) begin
        r_cpu_hold  <= 1'b0;
        r_load_done <= 1'b1;
      end
      if (r_state != S_ERR && w_next == S_ERR)
        r_load_error <= 1'b1;
    end
  end

  assign o_in_ready     = r_in_ready;
  assign o_mem_we       = r_mem_we;
  assign o_mem_addr     = r_mem_addr;
  assign o_mem_wdata    = r_mem_wdata;
  assign o_cpu_hold     = r_cpu_hold;
  assign o_load_done    = r_load_done;
  assign o_load_error   = r_load_error;
  assign o_words_loaded = r_word_idx;

endmodule
